// File: rtl/rf_pkg.sv
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared defaults, address-width helper and typedefs for the
//            integer register file and its busy scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   // Address width for a power-of-two register count; never narrower than 1.
   function automatic int rf_aw(input int nregs);
      return (nregs <= 2) ? 1 : $clog2(nregs);
   endfunction

   localparam int AW_DEF = rf_aw(NREGS_DEF);

   typedef logic [AW_DEF-1:0]   rf_addr_t;
   typedef logic [XLEN_DEF-1:0] rf_data_t;

   localparam rf_addr_t REG_ZERO = '0;

endpackage

`default_nettype wire

// File: rtl/rf_popcount.sv
// ============================================================================
// Module   : rf_popcount
// Brief    : Population count of an N-bit vector (busy-bit counter).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_popcount #(
   parameter int N  = 32,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]  vec,
   output logic [CW-1:0] cnt
);

   // Sum of set bits; a simple adder chain that synthesis flattens to a tree.
   always_comb begin
      cnt = '0;
      for (int k = 0; k < N; k++) begin
         cnt = cnt + CW'(vec[k]);
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Multi-read-port integer register file with per-register busy
//            scoreboard. x0 reads zero and is never busy.
//            Optional macro RF_BYPASS_EN: same-cycle write-to-read bypass.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
   import rf_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREGS = NREGS_DEF,
   parameter  int NRD   = 2,
   localparam int AW    = rf_aw(NREGS),
   localparam int CW    = $clog2(NREGS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_ready,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                flush,
   output logic [CW-1:0]       busy_cnt,
   output logic                wr_unexp
);

   logic                w_wr_vld;
   logic                w_iss_vld;
   logic [NREGS-1:0]    r_busy;
   logic [NREGS-1:0]    w_busy_nxt;
   logic [CW-1:0]       w_cnt_nxt;
   logic [CW-1:0]       r_busy_cnt;
   logic                r_wr_unexp;
   logic [XLEN-1:0]     w_mem [NREGS];

   assign w_wr_vld  = wr_en  && (wr_addr  != AW'(0));
   assign w_iss_vld = iss_en && (iss_addr != AW'(0));

   // x0 has no storage; it is a constant zero row.
   assign w_mem[0] = '0;

   genvar r;
   generate
      for (r = 1; r < NREGS; r++) begin : g_reg
         logic [XLEN-1:0] r_q;

         // One row of storage, loaded by a writeback addressed to it.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_q <= '0;
            end else if (w_wr_vld && (wr_addr == AW'(r))) begin
               r_q <= wr_data;
            end
         end

         assign w_mem[r] = r_q;
      end
   endgenerate

   // Next busy vector: flush wins over issue; issue after write so a new
   // producer on the same register keeps it busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (flush) begin
         w_busy_nxt = '0;
      end else begin
         if (w_wr_vld)  w_busy_nxt[wr_addr]  = 1'b0;
         if (w_iss_vld) w_busy_nxt[iss_addr] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   rf_popcount #(
      .N  (NREGS),
      .CW (CW)
   ) u_popcount (
      .vec (w_busy_nxt),
      .cnt (w_cnt_nxt)
   );

   // Busy vector, its count and the unexpected-write flag share one update
   // so busy_cnt always matches the busy bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
         r_wr_unexp <= 1'b0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_cnt_nxt;
         r_wr_unexp <= w_wr_vld && !r_busy[wr_addr] && !flush;
      end
   end

   assign busy_cnt = r_busy_cnt;
   assign wr_unexp = r_wr_unexp;

   genvar i;
   generate
      for (i = 0; i < NRD; i++) begin : g_rd
         logic [AW-1:0]   w_addr;
         logic [XLEN-1:0] w_stored;
         logic            w_not_busy;

         assign w_addr     = rd_addr[i*AW +: AW];
         assign w_stored   = w_mem[w_addr];
         assign w_not_busy = !r_busy[w_addr];

`ifdef RF_BYPASS_EN
         logic w_hit;
         // Forward the in-flight writeback when it targets this port.
         assign w_hit                  = w_wr_vld && (wr_addr == w_addr);
         assign rd_data[i*XLEN +: XLEN] = w_hit ? wr_data : w_stored;
         assign rd_ready[i]             = w_hit | w_not_busy;
`else
         assign rd_data[i*XLEN +: XLEN] = w_stored;
         assign rd_ready[i]             = w_not_busy;
`endif
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Scoreboard bench for regfile_scoreboard: directed test-plan
//            sequence followed by random traffic against a reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;
   localparam int CW    = 6;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NRD*AW-1:0]   rd_addr = '0;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_ready;
   logic                wr_en = 1'b0;
   logic [AW-1:0]       wr_addr = '0;
   logic [XLEN-1:0]     wr_data = '0;
   logic                iss_en = 1'b0;
   logic [AW-1:0]       iss_addr = '0;
   logic                flush = 1'b0;
   logic [CW-1:0]       busy_cnt;
   logic                wr_unexp;

   regfile_scoreboard #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NRD   (NRD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_ready (rd_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .flush    (flush),
      .busy_cnt (busy_cnt),
      .wr_unexp (wr_unexp)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] d;
      logic [1:0]  rdy;
      logic [5:0]  cnt;
      logic        unexp;
   } exp_t;

   exp_t exp_q[$];

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: architectural state after the most recent edge.
   logic [31:0] m_mem  [32];
   bit          m_busy [32];
   bit          m_unexp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
   endtask

   // Monitor: every cycle the DUT presents a full set of outputs; compare
   // them against the oldest expectation pushed by the driver.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_data0", rd_data[31:0],  e.d[31:0]);
            chk("rd_data1", rd_data[63:32], e.d[63:32]);
            chk("rd_ready0", 32'(rd_ready[0]), 32'(e.rdy[0]));
            chk("rd_ready1", 32'(rd_ready[1]), 32'(e.rdy[1]));
            chk("busy_cnt", 32'(busy_cnt), 32'(e.cnt));
            chk("wr_unexp", 32'(wr_unexp), 32'(e.unexp));
         end
      end
   end

   // Drive one cycle of inputs, record what the outputs must be this cycle,
   // then advance the model through the coming edge.
   task automatic step(input bit r, input bit we, input int wa, input logic [31:0] wd,
                       input bit ie, input int ia, input bit fl, input int a0, input int a1);
      exp_t e;
      int   a;
      int   cnt;
      logic [31:0] d;
      bit   rdy;
      @(posedge clk);
      #1;
      rst      = r;
      wr_en    = we;
      wr_addr  = wa[4:0];
      wr_data  = wd;
      iss_en   = ie;
      iss_addr = ia[4:0];
      flush    = fl;
      rd_addr  = {a1[4:0], a0[4:0]};

      for (int p = 0; p < 2; p++) begin
         a   = (p == 0) ? a0 : a1;
         d   = (a == 0) ? 32'h0 : m_mem[a];
         rdy = (a == 0) ? 1'b1 : !m_busy[a];
`ifdef RF_BYPASS_EN
         if (we && wa != 0 && wa == a) begin
            d   = wd;
            rdy = 1'b1;
         end
`endif
         e.d[p*32 +: 32] = d;
         e.rdy[p]        = rdy;
      end
      cnt = 0;
      for (int k = 0; k < 32; k++) if (m_busy[k]) cnt++;
      e.cnt   = cnt[5:0];
      e.unexp = m_unexp;
      exp_q.push_back(e);

      if (r) begin
         for (int k = 0; k < 32; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
         end
         m_unexp = 1'b0;
      end else begin
         m_unexp = we && (wa != 0) && !m_busy[wa] && !fl;
         if (we && wa != 0) m_mem[wa] = wd;
         if (fl) begin
            for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
         end else begin
            if (we && wa != 0) m_busy[wa] = 1'b0;
            if (ie && ia != 0) m_busy[ia] = 1'b1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wa, ia, a0, a1;
      bit r, we, ie, fl;
      // rst is high from time 0, so the first edge has already reset state.
      for (int k = 0; k < 32; k++) begin
         m_mem[k]  = '0;
         m_busy[k] = 1'b0;
      end
      m_unexp = 1'b0;

      // Reset, then sweep reads over every address.
      step(1, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 32; k += 2) step(0, 0, 0, 0, 0, 0, 0, k, k + 1);

      // Basic writes and x0 write.
      step(0, 1, 5, 32'h0000_000A, 0, 0, 0, 0, 0);
      step(0, 1, 6, 32'h0000_000F, 0, 0, 0, 0, 0);
      step(0, 1, 0, 32'h0000_DEAD, 0, 0, 0, 5, 6);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Issue x7, then write it back.
      step(0, 0, 0, 0, 1, 7, 0, 7, 0);
      step(0, 1, 7, 32'h0000_1234, 0, 0, 0, 7, 7);
      step(0, 0, 0, 0, 0, 0, 0, 7, 0);

      // Same-cycle issue and write to busy x9; unexpected write to x10.
      step(0, 0, 0, 0, 1, 9, 0, 9, 0);
      step(0, 1, 9, 32'h0000_0055, 1, 9, 0, 9, 0);
      step(0, 1, 10, 32'h0000_0011, 0, 0, 0, 9, 10);
      step(0, 0, 0, 0, 0, 0, 0, 10, 9);
      step(0, 0, 0, 0, 0, 0, 0, 10, 9);

      // Issue x1..x4, then flush with concurrent issue x8 and write x2.
      for (int k = 1; k <= 4; k++) step(0, 0, 0, 0, 1, k, 0, k, 0);
      step(0, 1, 2, 32'h0000_0077, 1, 8, 1, 8, 2);
      step(0, 0, 0, 0, 0, 0, 0, 8, 2);

      // Write x3 while reading it (bypass-dependent result).
      step(0, 1, 3, 32'h0000_0099, 0, 0, 0, 3, 3);
      step(0, 0, 0, 0, 0, 0, 0, 3, 0);

      // Random traffic with occasional flush and mid-stream reset.
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 99) < 2);
         we = !r && ($urandom_range(0, 99) < 50);
         ie = ($urandom_range(0, 99) < 45);
         fl = ($urandom_range(0, 99) < 4);
         wa = $urandom_range(0, 15);
         ia = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
         a0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 15);
         a1 = $urandom_range(0, 31);
         step(r, we, wa, $urandom, ie, ia, fl, a0, a1);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      @(posedge clk);
      #1;
      wr_en  = 1'b0;
      iss_en = 1'b0;
      flush  = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
